// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified instruction/data memory arbiter.
package mips_mem_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Which requester currently owns (or last owned) the memory port.
  typedef enum logic {
    OWNER_FETCH = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_t;

  // Access-size encodings shared by the core and the memory.
  localparam logic [1:0] LS_WORD  = 2'b00;
  localparam logic [1:0] LS_HALF  = 2'b01;
  localparam logic [1:0] LS_BYTE  = 2'b10;
  localparam logic [1:0] LS_BYTEU = 2'b11;

  // Round-robin pick: a lone requester wins; on contention the side that
  // did not win last time goes next.
  function automatic owner_t pick_owner(input logic   fetch_req,
                                        input logic   data_req,
                                        input owner_t last_grant);
    owner_t pick;
    if (fetch_req && data_req) begin
      pick = (last_grant == OWNER_FETCH) ? OWNER_DATA : OWNER_FETCH;
    end else if (data_req) begin
      pick = OWNER_DATA;
    end else begin
      pick = OWNER_FETCH;
    end
    return pick;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported unified memory between instruction fetch and the
// load/store stage. One requester at a time holds the port for LATENCY cycles;
// read data is registered and announced with a one-cycle ready pulse.
//
// Handshake: a requester raises *_req and holds it, with stable request
// fields, until it sees its *_ready pulse. Request fields are sampled only on
// the grant cycle. *_ready is high for exactly one cycle and *_rdata is valid
// in that cycle and stays put until that side's next completion. A *_req
// still high in the ready cycle is treated as a fresh request.
module unified_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  // Fetch side (read-only, word)
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_addr,
  output logic             i_ready,
  output logic [WIDTH-1:0] i_rdata,
  // Data side (load/store, word/half/byte)
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  input  logic [1:0]       d_ls_ctrl,
  output logic             d_ready,
  output logic [WIDTH-1:0] d_rdata,
  // Memory port
  output logic [WIDTH-1:0] mem_a,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  output logic [1:0]       mem_ls_ctrl,
  input  logic [WIDTH-1:0] mem_rd,
  // Hazard unit
  output logic             stall_f,
  output logic             stall_m,
  // Current FSM state for observation
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  owner_t           owner_q, owner_d;
  owner_t           last_grant_q, last_grant_d;
  logic [WIDTH-1:0] lat_addr_q, lat_addr_d;
  logic [WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic             lat_we_q, lat_we_d;
  logic [1:0]       lat_ls_q, lat_ls_d;
  logic             i_ready_q, i_ready_d;
  logic             d_ready_q, d_ready_d;
  logic [WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic   any_req;
  owner_t grant_owner;
  logic   busy;
  logic   last_cycle;

  assign any_req     = i_req | d_req;
  assign grant_owner = pick_owner(i_req, d_req, last_grant_q);
  assign busy        = (state_q == BUSY);
  assign last_cycle  = (cnt_q == '0);

  // Next-state: arbitrate in IDLE/DONE, count wait states in BUSY, capture on the last one.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lat_addr_d   = lat_addr_q;
    lat_wdata_d  = lat_wdata_q;
    lat_we_d     = lat_we_q;
    lat_ls_d     = lat_ls_q;
    i_ready_d    = 1'b0;
    d_ready_d    = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (any_req) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
          owner_d = grant_owner;
          if (grant_owner == OWNER_DATA) begin
            lat_addr_d  = d_addr;
            lat_wdata_d = d_wdata;
            lat_we_d    = d_we;
            lat_ls_d    = d_ls_ctrl;
          end else begin
            lat_addr_d  = i_addr;
            lat_wdata_d = '0;
            lat_we_d    = 1'b0;
            lat_ls_d    = LS_WORD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!last_cycle) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d      = DONE;
          last_grant_d = owner_q;
          if (owner_q == OWNER_DATA) begin
            d_rdata_d = mem_rd;
            d_ready_d = 1'b1;
          end else begin
            i_rdata_d = mem_rd;
            i_ready_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= OWNER_FETCH;
      last_grant_q <= OWNER_FETCH;
      lat_addr_q   <= '0;
      lat_wdata_q  <= '0;
      lat_we_q     <= 1'b0;
      lat_ls_q     <= LS_WORD;
      i_ready_q    <= 1'b0;
      d_ready_q    <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lat_addr_q   <= lat_addr_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_we_q     <= lat_we_d;
      lat_ls_q     <= lat_ls_d;
      i_ready_q    <= i_ready_d;
      d_ready_q    <= d_ready_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Memory port is driven only while BUSY; the single write strobe lands on the last wait state.
  always_comb begin
    mem_a       = busy ? lat_addr_q  : '0;
    mem_wd      = busy ? lat_wdata_q : '0;
    mem_ls_ctrl = busy ? lat_ls_q    : LS_WORD;
    mem_we      = lat_we_q & busy & last_cycle & ~reset;
  end

  assign i_ready   = i_ready_q;
  assign d_ready   = d_ready_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign stall_f   = i_req & ~i_ready_q;
  assign stall_m   = d_req & ~d_ready_q;
  assign dbg_state = state_q;

endmodule
